// File: rtl/stepper_move_controller.sv
// Stepper motor move controller: direction setup delay, fixed-width step pulses at a
// programmable period, step and absolute position tracking, abort and zero-length moves.
module stepper_move_controller #(
    parameter int unsigned PULSE_HIGH_CYCLES = 100,
    parameter int unsigned DIR_SETUP_CYCLES  = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        dir_in,
    input  logic [31:0] num_steps,
    input  logic [31:0] period,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] steps_done,
    output logic [31:0] position
);

    localparam logic [31:0] HighLen   = 32'(PULSE_HIGH_CYCLES);
    localparam logic [31:0] SetupLen  = 32'(DIR_SETUP_CYCLES);
    localparam logic [31:0] MinPeriod = 32'(2 * PULSE_HIGH_CYCLES);

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] num_q, num_d;
    logic [31:0] period_q, period_d;
    logic        dir_q, dir_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] pos_q, pos_d;
    logic        done_q, done_d;

    logic [31:0] eff_period;
    logic [31:0] low_last;

    // Period is clamped so the low phase is never shorter than the high phase.
    assign eff_period = (period > MinPeriod) ? period : MinPeriod;
    assign low_last   = period_q - HighLen - 32'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        period_d = period_q;
        dir_d    = dir_q;
        steps_d  = steps_q;
        pos_d    = pos_q;
        done_d   = 1'b0;

        if (state_q != StIdle && abort) begin
            state_d = StIdle;
            cnt_d   = 32'd0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        steps_d = 32'd0;
                        if (num_steps == 32'd0) begin
                            done_d = 1'b1;
                        end else begin
                            num_d    = num_steps;
                            period_d = eff_period;
                            dir_d    = dir_in;
                            cnt_d    = 32'd0;
                            state_d  = StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == SetupLen - 32'd1) begin
                        cnt_d   = 32'd0;
                        state_d = StHigh;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StHigh: begin
                    if (cnt_q == HighLen - 32'd1) begin
                        cnt_d   = 32'd0;
                        steps_d = steps_q + 32'd1;
                        pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                        state_d = StLow;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StLow: begin
                    if (cnt_q == low_last) begin
                        cnt_d = 32'd0;
                        if (steps_q == num_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StHigh;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 32'd0;
            num_q    <= 32'd0;
            period_q <= 32'd0;
            dir_q    <= 1'b0;
            steps_q  <= 32'd0;
            pos_q    <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
        end
    end

    assign step_out   = (state_q == StHigh);
    assign busy       = (state_q != StIdle);
    assign dir_out    = dir_q;
    assign done       = done_q;
    assign steps_done = steps_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_stepper_move_controller.sv
// Bench for stepper_move_controller: table of moves checked cycle by cycle against
// spec timing, end-of-move results through a scoreboard, plus reset/abort sequences.
module tb_stepper_move_controller;

    localparam int PH        = 2;
    localparam int DS        = 3;
    localparam int MaxCycles = 60;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        dir_in;
    logic [31:0] num_steps;
    logic [31:0] period;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [31:0] steps_done;
    logic [31:0] position;

    always #5 clock = ~clock;

    stepper_move_controller #(
        .PULSE_HIGH_CYCLES(PH),
        .DIR_SETUP_CYCLES (DS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .dir_in    (dir_in),
        .num_steps (num_steps),
        .period    (period),
        .step_out  (step_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .done      (done),
        .steps_done(steps_done),
        .position  (position)
    );

    typedef struct {
        logic        dir;
        logic [31:0] num;
        logic [31:0] per;
        int          abort_cyc;
        int          bstart_cyc;
        int          done_cyc;
        logic [31:0] exp_steps;
        logic [31:0] exp_pos;
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic [31:0] steps;
        logic [31:0] pos;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic model_dir = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        int   eff;
        bit   seen;
        logic exp_step;
        logic exp_busy;
        v = vecs[idx];
        eff = (v.per > 32'(2 * PH)) ? int'(v.per) : 2 * PH;
        start     = 1'b1;
        abort     = 1'b0;
        dir_in    = v.dir;
        num_steps = v.num;
        period    = v.per;
        sb.push_back('{v.done_cyc, v.exp_steps, v.exp_pos});
        if (v.num != 32'd0) model_dir = v.dir;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 1; c <= MaxCycles && !seen; c++) begin
            abort = (c == v.abort_cyc);
            start = (c == v.bstart_cyc);
            if (start) begin
                dir_in    = ~v.dir;
                num_steps = 32'd7;
                period    = 32'd3;
            end
            exp_busy = (c < v.done_cyc);
            exp_step = exp_busy && (c >= DS + 1) && (((c - DS - 1) % eff) < PH);
            chk($sformatf("v%0d c%0d step_out", idx, c), {31'd0, step_out}, {31'd0, exp_step});
            chk($sformatf("v%0d c%0d busy", idx, c), {31'd0, busy}, {31'd0, exp_busy});
            chk($sformatf("v%0d c%0d done", idx, c), {31'd0, done},
                {31'd0, (c == v.done_cyc)});
            chk($sformatf("v%0d c%0d dir_out", idx, c), {31'd0, dir_out}, {31'd0, model_dir});
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk($sformatf("v%0d done_cycle", idx), 32'(c), 32'(e.done_cyc));
                chk($sformatf("v%0d steps_done", idx), steps_done, e.steps);
                chk($sformatf("v%0d position", idx), position, e.pos);
            end else begin
                tick();
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d timeout: no done within %0d cycles", idx, MaxCycles);
            sb.delete();
        end
        tick();
        chk($sformatf("v%0d done_one_cycle", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d idle_after", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // dir, num, period, abort_cyc, busy_start_cyc, done_cyc, steps, position
        vecs[0] = '{1'b1, 32'd3, 32'd5, -1, 9, 19, 32'd3, 32'd3};
        vecs[1] = '{1'b0, 32'd2, 32'd1, -1, -1, 12, 32'd2, 32'd1};
        vecs[2] = '{1'b1, 32'd5, 32'd6, 11, -1, 12, 32'd1, 32'd2};
        vecs[3] = '{1'b0, 32'd0, 32'd9, -1, -1, 1, 32'd0, 32'd2};
        vecs[4] = '{1'b0, 32'd2, 32'd0, -1, -1, 12, 32'd2, 32'd0};
        vecs[5] = '{1'b0, 32'd1, 32'd4, -1, -1, 8, 32'd1, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 32'd1, 32'd4, -1, -1, 8, 32'd1, 32'd0};
        vecs[7] = '{1'b1, 32'd2, 32'd7, -1, 5, 18, 32'd2, 32'd2};
        vecs[8] = '{1'b1, 32'd4, 32'd5, 2, -1, 3, 32'd0, 32'd2};
        vecs[9] = '{1'b0, 32'd3, 32'd5, 7, -1, 8, 32'd1, 32'd1};

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        dir_in    = 1'b0;
        num_steps = 32'd0;
        period    = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset step_out", {31'd0, step_out}, 32'd0);
        chk("reset dir_out", {31'd0, dir_out}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset steps_done", steps_done, 32'd0);
        chk("reset position", position, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Abort and start together in IDLE: nothing starts, no done.
        start     = 1'b1;
        abort     = 1'b1;
        dir_in    = 1'b1;
        num_steps = 32'd3;
        period    = 32'd5;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("abort_start c%0d busy", c), {31'd0, busy}, 32'd0);
            chk($sformatf("abort_start c%0d done", c), {31'd0, done}, 32'd0);
            chk($sformatf("abort_start c%0d step_out", c), {31'd0, step_out}, 32'd0);
            tick();
        end
        chk("abort_start position", position, 32'd1);
        chk("abort_start dir_out", {31'd0, dir_out}, {31'd0, model_dir});

        // Reset in cycle 7 of a 4-step move.
        start     = 1'b1;
        dir_in    = 1'b1;
        num_steps = 32'd4;
        period    = 32'd5;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("rst_mid busy before", {31'd0, busy}, 32'd1);
        chk("rst_mid position before", position, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid step_out", {31'd0, step_out}, 32'd0);
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid position", position, 32'd0);
        chk("rst_mid steps_done", steps_done, 32'd0);
        chk("rst_mid dir_out", {31'd0, dir_out}, 32'd0);
        for (int c = 8; c < 38; c++) begin
            chk($sformatf("rst_mid c%0d done", c), {31'd0, done}, 32'd0);
            chk($sformatf("rst_mid c%0d busy", c), {31'd0, busy}, 32'd0);
            tick();
        end

        // Reset overrides a simultaneous start.
        reset     = 1'b1;
        start     = 1'b1;
        dir_in    = 1'b1;
        num_steps = 32'd2;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rst_start busy later", {31'd0, busy}, 32'd0);
        chk("rst_start dir_out", {31'd0, dir_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
